// File: rtl/wb_port_arbiter.sv
// Round-robin write-back port arbiter with a destination-register scoreboard.
// One requester wins per cycle; its result reaches the register file one cycle later.
module wb_port_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int RW = $clog2(NREG)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0][RW-1:0]   req_wreg,
  input  logic [NREQ-1:0][XLEN-1:0] req_wdata,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      claim_valid,
  input  logic [RW-1:0]             claim_reg,
  input  logic                      flush,
  output logic                      o_wback,
  output logic [RW-1:0]             o_wreg,
  output logic [XLEN-1:0]           o_wdata,
  output logic [1:0]                o_src,
  output logic [NREG-1:0]           pending
);

  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [SW-1:0]   last;
  logic [SW-1:0]   sel;
  logic [SW-1:0]   idx;
  logic            hit;
  logic            xfer;
  logic [RW-1:0]   wreg_sel;
  logic [XLEN-1:0] wdata_sel;
  logic [NREG-1:0] pend_n;

  // Search starts just after the most recent winner.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = SW'((int'(last) + k) % NREQ);
      if (!hit && req_valid[idx]) begin
        hit = 1'b1;
        sel = idx;
      end
    end
  end

  assign xfer      = hit && !rst && !flush;
  assign req_ready = xfer ? (NREQ'(1) << sel) : '0;
  assign wreg_sel  = req_wreg[sel];
  assign wdata_sel = req_wdata[sel];

  // A claim landing with a write to the same register keeps the new reservation.
  always_comb begin
    pend_n = pending;
    if (xfer)
      pend_n[wreg_sel] = 1'b0;
    if (claim_valid && claim_reg != '0)
      pend_n[claim_reg] = 1'b1;
    if (flush)
      pend_n = '0;
    pend_n[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last    <= SW'(NREQ - 1);
      o_wback <= 1'b0;
      o_wreg  <= '0;
      o_wdata <= '0;
      o_src   <= '0;
      pending <= '0;
    end else begin
      o_wback <= xfer && (wreg_sel != '0);
      pending <= pend_n;
      if (xfer) begin
        last    <= sel;
        o_wreg  <= wreg_sel;
        o_wdata <= wdata_sel;
        o_src   <= 2'(sel);
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: driver queues expected write-back results,
// a monitor compares them against the registered outputs.
module tb_wb_port_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       req_valid;
  logic [2:0][4:0]  req_wreg;
  logic [2:0][31:0] req_wdata;
  logic [2:0]       req_ready;
  logic             claim_valid;
  logic [4:0]       claim_reg;
  logic             flush;
  logic             o_wback;
  logic [4:0]       o_wreg;
  logic [31:0]      o_wdata;
  logic [1:0]       o_src;
  logic [31:0]      pending;

  wb_port_arbiter #(.NREQ(3), .XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wreg(req_wreg), .req_wdata(req_wdata),
    .req_ready(req_ready),
    .claim_valid(claim_valid), .claim_reg(claim_reg), .flush(flush),
    .o_wback(o_wback), .o_wreg(o_wreg), .o_wdata(o_wdata),
    .o_src(o_src), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        wb;
    logic [4:0]  wreg;
    logic [31:0] wd;
    logic [1:0]  src;
    logic [31:0] pend;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h",
               nm, cyc, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("o_wback", 32'(o_wback), 32'(e.wb));
        chk("o_wreg",  32'(o_wreg),  32'(e.wreg));
        chk("o_wdata", o_wdata, e.wd);
        chk("o_src",   32'(o_src),   32'(e.src));
        chk("pending", pending, e.pend);
      end
    end
  end

  task automatic drive(input logic [2:0] v, input logic cv,
                       input logic [4:0] cr, input logic fl,
                       input logic r);
    @(negedge clk);
    req_valid   = v;
    claim_valid = cv;
    claim_reg   = cr;
    flush       = fl;
    rst         = r;
  endtask

  task automatic expect_out(input logic [2:0] er, input logic wb,
                            input logic [4:0] wr, input logic [31:0] wd,
                            input logic [1:0] src, input logic [31:0] pd);
    exp_t e;
    #1;
    chk("req_ready", 32'(req_ready), 32'(er));
    e.cyc  = cyc + 1;
    e.wb   = wb;
    e.wreg = wr;
    e.wd   = wd;
    e.src  = src;
    e.pend = pd;
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_wreg = '0;
    req_wdata = '0;
    claim_valid = 1'b0;
    claim_reg = '0;
    flush = 1'b0;

    // reset, with requesters already valid
    drive(3'b000, 0, 0, 0, 1); expect_out(3'b000, 0, 0, 0, 0, 0);
    req_wreg[0] = 5'd1; req_wdata[0] = 32'hA;
    req_wreg[1] = 5'd2; req_wdata[1] = 32'hB;
    req_wreg[2] = 5'd3; req_wdata[2] = 32'hC;
    drive(3'b111, 0, 0, 0, 1); expect_out(3'b000, 0, 0, 0, 0, 0);

    // three requesters, first grants 0,1,2
    drive(3'b111, 0, 0, 0, 0); expect_out(3'b001, 1, 1, 32'hA, 0, 0);
    drive(3'b110, 0, 0, 0, 0); expect_out(3'b010, 1, 2, 32'hB, 1, 0);
    drive(3'b100, 0, 0, 0, 0); expect_out(3'b100, 1, 3, 32'hC, 2, 0);
    drive(3'b000, 0, 0, 0, 0); expect_out(3'b000, 0, 3, 32'hC, 2, 0);

    // write to x0
    req_wreg[1] = 5'd0; req_wdata[1] = 32'hDEAD;
    drive(3'b010, 0, 0, 0, 0); expect_out(3'b010, 0, 0, 32'hDEAD, 1, 0);

    // scoreboard claim / release / same-edge claim+write
    drive(3'b000, 1, 5, 0, 0); expect_out(3'b000, 0, 0, 32'hDEAD, 1, 32'h20);
    req_wreg[0] = 5'd5; req_wdata[0] = 32'h55AA;
    drive(3'b001, 0, 0, 0, 0); expect_out(3'b001, 1, 5, 32'h55AA, 0, 0);
    drive(3'b000, 1, 5, 0, 0); expect_out(3'b000, 0, 5, 32'h55AA, 0, 32'h20);
    req_wreg[1] = 5'd5; req_wdata[1] = 32'h77;
    drive(3'b010, 1, 5, 0, 0); expect_out(3'b010, 1, 5, 32'h77, 1, 32'h20);

    // flush clears scoreboard and blocks grants
    drive(3'b000, 1, 1, 0, 0); expect_out(3'b000, 0, 5, 32'h77, 1, 32'h22);
    drive(3'b000, 1, 2, 0, 0); expect_out(3'b000, 0, 5, 32'h77, 1, 32'h26);
    req_wreg[2] = 5'd9; req_wdata[2] = 32'h99;
    drive(3'b100, 1, 3, 1, 0); expect_out(3'b000, 0, 5, 32'h77, 1, 0);
    drive(3'b100, 0, 0, 0, 0); expect_out(3'b100, 1, 9, 32'h99, 2, 0);

    // fairness between 0 and 2, then 1 joins
    req_wreg[0] = 5'd4; req_wdata[0] = 32'h40;
    drive(3'b001, 0, 0, 0, 0); expect_out(3'b001, 1, 4, 32'h40, 0, 0);
    req_wreg[2] = 5'd6; req_wdata[2] = 32'h60;
    drive(3'b101, 0, 0, 0, 0); expect_out(3'b100, 1, 6, 32'h60, 2, 0);
    drive(3'b101, 0, 0, 0, 0); expect_out(3'b001, 1, 4, 32'h40, 0, 0);
    drive(3'b101, 0, 0, 0, 0); expect_out(3'b100, 1, 6, 32'h60, 2, 0);
    drive(3'b101, 0, 0, 0, 0); expect_out(3'b001, 1, 4, 32'h40, 0, 0);
    req_wreg[1] = 5'd8; req_wdata[1] = 32'h80;
    drive(3'b111, 0, 0, 0, 0); expect_out(3'b010, 1, 8, 32'h80, 1, 0);
    drive(3'b101, 0, 0, 0, 0); expect_out(3'b100, 1, 6, 32'h60, 2, 0);

    // write followed by reset
    req_wreg[1] = 5'd7; req_wdata[1] = 32'h55;
    drive(3'b010, 1, 7, 0, 0); expect_out(3'b010, 1, 7, 32'h55, 1, 32'h80);
    drive(3'b000, 0, 0, 0, 1); expect_out(3'b000, 0, 0, 0, 0, 0);

    // pointer back to requester 0 after reset
    req_wreg[0] = 5'd1; req_wdata[0] = 32'hA;
    req_wreg[1] = 5'd2; req_wdata[1] = 32'hB;
    req_wreg[2] = 5'd3; req_wdata[2] = 32'hC;
    drive(3'b111, 0, 0, 0, 0); expect_out(3'b001, 1, 1, 32'hA, 0, 0);
    drive(3'b000, 0, 0, 0, 0); expect_out(3'b000, 0, 1, 32'hA, 0, 0);

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameters SHALL be: NREQ, default 3, number of write-port requesters (2..4); XLEN, default 32, data width; NREG, default 32, architectural registers (index width clog2(NREG)=5).
REQ-002 Reset SHALL be rst, synchronous, active-high; clock SHALL be clk.
REQ-003 Ports SHALL be, one per line:
 clk  in  1  clock
 rst  in  1  synchronous active-high reset
 req_valid  in  NREQ  requester i holds a result
 req_wreg  in  NREQ x 5  destination register per requester
 req_wdata  in  NREQ x XLEN  result data per requester
 req_ready  out  NREQ  requester i's transfer is accepted this cycle
 claim_valid  in  1  decode reserves a destination register
 claim_reg  in  5  register being reserved
 flush  in  1  pipeline redirect; abort all in-flight writes
 o_wback  out  1  register-file write enable
 o_wreg  out  5  register-file write index
 o_wdata  out  XLEN  register-file write data
 o_src  out  2  index of requester that produced current write
 pending  out  NREG  scoreboard, bit r set = write to r outstanding

Function
REQ-004 Transfer SHALL occur for requester i exactly when req_valid[i] and req_ready[i] are both 1 at a rising clk edge.
REQ-005 At most one req_ready bit SHALL be 1 per cycle; req_ready SHALL be combinational from req_valid, the priority pointer and flush.
REQ-006 req_ready[i] SHALL never be 1 when req_valid[i] is 0.
REQ-007 Arbitration SHALL be round-robin: search starts at (last+1) mod NREQ, where last is the most recently granted requester; first valid requester in search order is granted.
REQ-008 last SHALL update only on a transfer; idle cycles leave it unchanged.
REQ-009 Requesters SHALL hold req_valid, req_wreg and req_wdata stable until transfer; arbiter behaviour under payload change without transfer is unspecified.
REQ-010 Outputs o_wback/o_wreg/o_wdata/o_src SHALL be registered: transfer at edge N appears on the outputs for exactly the cycle after edge N (latency 1).
REQ-011 o_wback SHALL be 1 after a transfer with req_wreg != 0, and 0 after a transfer to x0 or a cycle with no transfer; o_wreg/o_wdata/o_src SHALL load on every transfer, including x0.
REQ-012 No requester SHALL wait more than NREQ-1 transfers of other requesters while holding req_valid.
REQ-013 flush=1 SHALL force all req_ready to 0, next-cycle o_wback to 0, and clear all pending bits; last SHALL be unchanged.
REQ-014 pending[r] SHALL be set at the edge where claim_valid=1, claim_reg=r, r != 0, flush=0.
REQ-015 pending[r] SHALL clear at the edge where a transfer with req_wreg=r occurs.
REQ-016 Claim and transfer to the same r at the same edge SHALL leave pending[r]=1 (new reservation wins).
REQ-017 pending[0] SHALL be 0 at all times; claims of x0 SHALL be ignored.
REQ-018 A transfer to r with pending[r]=0 SHALL still write normally (o_wback per REQ-011); pending stays 0.

Reset
REQ-019 While rst=1 at an edge: o_wback, o_wreg, o_wdata, o_src, pending SHALL become 0; last SHALL become NREQ-1 so requester 0 wins first.
REQ-020 While rst=1, req_ready SHALL be all 0; rst SHALL take precedence over flush, claim and transfer.
REQ-021 Reset asserted mid-operation SHALL discard any accepted-but-not-yet-output write (o_wback=0 the cycle after).

Verification
REQ-022 Post-reset, all three valid (wreg 1/2/3, wdata 0xA/0xB/0xC) held -> grants 0,1,2 on consecutive cycles; outputs (1,0xA),(2,0xB),(3,0xC) each one cycle later, o_wback=1.
REQ-023 Requester 1 alone valid, wreg=0, wdata=0xDEAD -> req_ready[1]=1, next cycle o_wback=0, o_src=1.
REQ-024 claim_reg=5 -> pending=0x20; later transfer wreg=5 -> pending=0 same edge as o_wreg=5 loads; claim 5 + transfer 5 same edge -> pending stays 0x20.
REQ-025 pending=0x26, requester 2 valid, flush=1 -> req_ready=0, pending=0 next cycle, o_wback=0; flush drop -> requester 2 granted.
REQ-026 Requester 0 and 2 continuously valid, last=0 -> grant sequence 2,0,2,0; requester 1 asserted mid-run -> granted within 2 transfers.
REQ-027 rst=1 asserted the edge after a transfer of (wreg 7, 0x55) -> o_wback=0, o_wdata=0, pending=0 following cycle.
